// File: rtl/tx_frame_reader.sv
// TX frame reader: streams a frame from a byte buffer to a MAC through a two-entry output buffer.
// Optional inter-frame gap compiled in with macro TX_READER_IFG_EN.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start with a non-zero length
// S_RUN  | issuing reads and streaming bytes until the tlast handshake
// S_GAP  | inter-frame idle time (only with TX_READER_IFG_EN)
module tx_frame_reader #(
  parameter int ADDR_W     = 11,
  parameter int IFG_CYCLES = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] frame_len,
  output logic              mem_ena,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              done
);

`ifdef TX_READER_IFG_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  logic [GAP_W-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_addr, reads_left, beats_left;
  logic [1:0]        cnt;
  logic              pend;
  logic [7:0]        buf0, buf1;
  logic              pop, issue, accept, last_hs, finish;
  logic [2:0]        occ_after;

  // The byte returning on mem_rdata is treated as the buffer head when the buffer is empty.
  assign m_tvalid = (cnt != 2'd0) || pend;
  assign m_tdata  = (cnt != 2'd0) ? buf0 : (pend ? mem_rdata : 8'h00);
  assign m_tlast  = m_tvalid && (beats_left == ADDR_W'(1));
  assign pop      = m_tvalid && m_tready;
  assign last_hs  = pop && m_tlast;
  assign occ_after = {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};
  assign issue    = (state == S_RUN) && (reads_left != '0) && (occ_after < 3'd2);
  assign mem_ena  = issue;
  assign mem_addr = rd_addr;
  assign busy     = (state != S_IDLE) || done;
  assign accept   = (state == S_IDLE) && (state_nxt == S_RUN);

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      S_IDLE: if (start && (frame_len != '0) && !done) state_nxt = S_RUN;
      S_RUN: begin
        if (last_hs) begin
`ifdef TX_READER_IFG_EN
          state_nxt = S_GAP;
`else
          state_nxt = S_IDLE;
          finish    = 1'b1;
`endif
        end
      end
`ifdef TX_READER_IFG_EN
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = S_IDLE;
          finish    = 1'b1;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      rd_addr    <= '0;
      reads_left <= '0;
      beats_left <= '0;
      cnt        <= 2'd0;
      pend       <= 1'b0;
      buf0       <= 8'h00;
      buf1       <= 8'h00;
`ifdef TX_READER_IFG_EN
      gap_cnt    <= '0;
`endif
    end else begin
      state <= state_nxt;
      done  <= finish;
      pend  <= issue;
      cnt   <= occ_after[1:0];
      if (accept) begin
        rd_addr    <= start_addr;
        reads_left <= frame_len;
        beats_left <= frame_len;
      end else begin
        if (issue) begin
          rd_addr    <= rd_addr + 1'b1;
          reads_left <= reads_left - 1'b1;
        end
        if (pop) beats_left <= beats_left - 1'b1;
      end
      // Entries stay in arrival order; cnt+pend never exceeds two.
      if (pop) begin
        if (cnt == 2'd2) buf0 <= buf1;
        else             buf0 <= mem_rdata;
      end else if (pend) begin
        if (cnt == 2'd0) buf0 <= mem_rdata;
        else             buf1 <= mem_rdata;
      end
`ifdef TX_READER_IFG_EN
      if (state == S_RUN && state_nxt == S_GAP) gap_cnt <= GAP_W'(IFG_CYCLES - 1);
      else if (state == S_GAP)                 gap_cnt <= gap_cnt - 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_tx_frame_reader.sv
// Directed + randomized bench for tx_frame_reader with a behavioural buffer and expected-byte queue.
module tb_tx_frame_reader;
  localparam int ADDR_W = 11;
  localparam int IFG    = 12;
`ifdef TX_READER_IFG_EN
  localparam int G = IFG;
`else
  localparam int G = 0;
`endif

  logic              clk = 1'b0;
  logic              rst, start, m_tready;
  logic [ADDR_W-1:0] start_addr, frame_len, mem_addr;
  logic              mem_ena, m_tvalid, m_tlast, busy, done;
  logic [7:0]        mem_rdata, m_tdata;
  logic [7:0]        mem [0:2047];
  int                n_cmp = 0;
  int                n_bad = 0;

  tx_frame_reader #(.ADDR_W(ADDR_W), .IFG_CYCLES(IFG)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .frame_len(frame_len),
    .mem_ena(mem_ena), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read buffer: data valid the cycle after mem_ena.
  always @(posedge clk) if (mem_ena) mem_rdata <= mem[mem_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tr(input int mode, input int idx);
    case (mode)
      0:       return 1'b1;
      1:       return ((idx % 4) == 0) || ((idx % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_frame(input int addr, input int len, input int mode,
                           input int abort_at, input bit gap_poke);
    logic [7:0] exq[$];
    logic [7:0] pd;
    int exp_addr, reads, beats, idx, first_v, hs_idx, done_idx, budget;
    bit pv, pr, pl, aborted;
    for (int i = 0; i < len; i++) exq.push_back(mem[(addr + i) % 2048]);
    exp_addr = addr; reads = 0; beats = 0; first_v = -1; hs_idx = -1; done_idx = -1;
    pv = 0; pr = 0; pl = 0; pd = 8'h00; aborted = 0;
    budget = len * 4 + 40 + G;

    @(negedge clk);
    start = 1'b1; start_addr = 11'(addr); frame_len = 11'(len); m_tready = 1'b1;
    #1;
    check("idle_before_start", busy, 1'b0);
    check("done_low_before_start", done, 1'b0);

    for (idx = 0; idx < budget; idx++) begin
      @(negedge clk);
      start = 1'b0;
      m_tready = tr(mode, idx);
      if (gap_poke && hs_idx >= 0 && idx == hs_idx + 3) begin
        start = 1'b1; start_addr = 11'(addr); frame_len = 11'd3;
      end
      #1;
      check("busy", busy, 1'b1);
      if (idx == 0) check("first_read_ena", mem_ena, 1'b1);
      if (mem_ena) begin
        if (reads >= len) check("extra_read", reads, len - 1);
        check("rd_addr", mem_addr, exp_addr);
        exp_addr = (exp_addr + 1) % 2048;
        reads++;
      end
      if (m_tvalid && first_v < 0) begin
        first_v = idx;
        check("first_valid_latency", idx, 1);
      end
      if (pv && !pr) begin
        check("stall_valid", m_tvalid, 1'b1);
        check("stall_data", m_tdata, pd);
        check("stall_last", m_tlast, pl);
      end
      if (m_tvalid && m_tready) begin
        if (beats >= len) check("extra_beat", beats, len - 1);
        else begin
          check("beat_data", m_tdata, exq[beats]);
          check("beat_last", m_tlast, beats == len - 1);
        end
        if (m_tlast) hs_idx = idx;
        beats++;
      end
      check("occupancy_le2", (reads - beats) <= 2, 1'b1);
      pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast;
      if (done) begin
        check("done_timing", idx, hs_idx + 1 + G);
        done_idx = idx;
        break;
      end
      if (abort_at > 0 && beats == abort_at) begin
        aborted = 1;
        break;
      end
    end

    if (aborted) begin
      @(negedge clk);
      rst = 1'b1; start = 1'b0;
      @(posedge clk);
      #1;
      check("abort_mem_ena", mem_ena, 1'b0);
      check("abort_mem_addr", mem_addr, 0);
      check("abort_tdata", m_tdata, 0);
      check("abort_tvalid", m_tvalid, 1'b0);
      check("abort_tlast", m_tlast, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_no_done", done, 1'b0);
    end else begin
      check("done_seen", done_idx >= 0, 1'b1);
      check("read_total", reads, len);
      check("beat_total", beats, len);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; m_tready = 1'b0; start_addr = '0; frame_len = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_mem_ena", mem_ena, 1'b0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tlast", m_tlast, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    run_frame(0, 64, 0, 0, 1'b0);

    mem[2045] = 8'hA1; mem[2046] = 8'hA2; mem[2047] = 8'hA3; mem[0] = 8'hB1; mem[1] = 8'hB2;
    run_frame(2045, 5, 0, 0, 1'b0);

    run_frame($urandom_range(0, 2047), 10, 1, 0, 1'b0);
    run_frame($urandom_range(0, 2047), 1, 0, 0, 1'b0);
    run_frame($urandom_range(0, 2047), 1, 1, 0, 1'b0);

    @(negedge clk);
    start = 1'b1; start_addr = 11'd100; frame_len = 11'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      check("len0_busy", busy, 1'b0);
      check("len0_no_read", mem_ena, 1'b0);
    end

    run_frame($urandom_range(0, 2047), 20, 0, 3, 1'b0);
    run_frame($urandom_range(0, 2047), 4, 0, 0, 1'b0);

    for (int f = 0; f < 6; f++)
      run_frame($urandom_range(0, 2047), $urandom_range(1, 40), $urandom_range(0, 2), 0, 1'b0);

`ifdef TX_READER_IFG_EN
    run_frame($urandom_range(0, 2047), 8, 0, 0, 1'b1);
    run_frame($urandom_range(0, 2047), 3, 2, 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
